// File: rtl/sram_arbiter_if.sv
// Requester and sram pin bundle for sram_arbiter.
// The slave view belongs to the arbiter; the master view belongs to the requesters and the sram.
interface sram_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 9
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  rvalid0;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic                  sram_en;
    logic                  sram_we;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic [DATA_WIDTH-1:0] sram_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               sram_en, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of a single-port sram with 1-cycle read latency.
// Per-cycle combinational grant, registered read-return tag, starvation guard for port 1.
module sram_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned PRIO0      = 1,
    parameter int unsigned MAX_WAIT   = 15
) (
    input  logic           clk,
    input  logic           reset,
    sram_arbiter_if.slave  bus
);
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    logic              last_q, last_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        rtag_q, rtag_d;
    logic              both_c;
    logic              pick1_c;
    logic              gnt0_c;
    logic              gnt1_c;

    // Winner selection; grants are held off for the whole reset cycle.
    always_comb begin
        both_c  = bus.req0 & bus.req1;
        pick1_c = bus.req1;
        if (both_c) begin
            if (PRIO0 != 0) begin
                pick1_c = (wait_q == WAIT_W'(MAX_WAIT));
            end else begin
                pick1_c = ~last_q;
            end
        end
        gnt0_c = ~reset & bus.req0 & ~pick1_c;
        gnt1_c = ~reset & bus.req1 &  pick1_c;
    end

    // Sram pin mux: winner's request, or all-zero when idle.
    always_comb begin
        bus.sram_en    = gnt0_c | gnt1_c;
        bus.sram_we    = 1'b0;
        bus.sram_addr  = ADDR_WIDTH'(0);
        bus.sram_wdata = DATA_WIDTH'(0);
        if (gnt1_c) begin
            bus.sram_we    = bus.we1;
            bus.sram_addr  = bus.addr1;
            bus.sram_wdata = bus.wdata1;
        end else if (gnt0_c) begin
            bus.sram_we    = bus.we0;
            bus.sram_addr  = bus.addr0;
            bus.sram_wdata = bus.wdata0;
        end
    end

    // Next-state: round-robin pointer, port-1 starvation counter, read-return tag.
    always_comb begin
        last_d = last_q;
        wait_d = wait_q;
        rtag_d = {gnt1_c & ~bus.we1, gnt0_c & ~bus.we0};
        if (gnt0_c) begin
            last_d = 1'b0;
        end
        if (gnt1_c) begin
            last_d = 1'b1;
        end
        if (!bus.req1 || gnt1_c) begin
            wait_d = WAIT_W'(0);
        end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
            wait_q <= WAIT_W'(0);
            rtag_q <= 2'b00;
        end else begin
            last_q <= last_d;
            wait_q <= wait_d;
            rtag_q <= rtag_d;
        end
    end

    // Read data is shared; rvalid tells each port whether it is theirs.
    assign bus.gnt0    = gnt0_c;
    assign bus.gnt1    = gnt1_c;
    assign bus.rvalid0 = rtag_q[0];
    assign bus.rvalid1 = rtag_q[1];
    assign bus.rdata0  = bus.sram_rdata;
    assign bus.rdata1  = bus.sram_rdata;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: fixed-priority instance (a) and round-robin instance (b),
// each with a behavioural 1-cycle-latency sram; read returns of (a) go through a scoreboard.
module tb_sram_arbiter;
    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;

    typedef struct {
        int         due;
        logic       port;
        logic [7:0] data;
    } rd_exp_t;

    rd_exp_t sb[$];

    logic [7:0] mem_a [0:511];
    logic [7:0] mem_b [0:511];

    sram_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(9)) busa ();
    sram_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(9)) busb ();

    sram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(9), .PRIO0(1), .MAX_WAIT(15)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (busa.slave)
    );

    sram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(9), .PRIO0(0), .MAX_WAIT(15)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (busb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural sram models.
    always @(posedge clk) begin
        if (busa.sram_en && busa.sram_we) mem_a[busa.sram_addr] <= busa.sram_wdata;
        if (busa.sram_en && !busa.sram_we) busa.sram_rdata <= mem_a[busa.sram_addr];
        if (busb.sram_en && busb.sram_we) mem_b[busb.sram_addr] <= busb.sram_wdata;
        if (busb.sram_en && !busb.sram_we) busb.sram_rdata <= mem_b[busb.sram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_rd(input logic port, input logic [7:0] data);
        rd_exp_t e;
        e.due  = cyc + 1;
        e.port = port;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        busa.req0 = 1'b0; busa.req1 = 1'b0; busa.we0 = 1'b0; busa.we1 = 1'b0;
        busa.addr0 = 9'h0; busa.addr1 = 9'h0; busa.wdata0 = 8'h0; busa.wdata1 = 8'h0;
        busb.req0 = 1'b0; busb.req1 = 1'b0; busb.we0 = 1'b0; busb.we1 = 1'b0;
        busb.addr0 = 9'h0; busb.addr1 = 9'h0; busb.wdata0 = 8'h0; busb.wdata1 = 8'h0;
    endtask

    // Read-return monitor for instance a; instance b only ever sees writes.
    always @(negedge clk) begin
        rd_exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("rvalid_hit",   32'(e.port ? busa.rvalid1 : busa.rvalid0), 32'd1);
            check("rvalid_other", 32'(e.port ? busa.rvalid0 : busa.rvalid1), 32'd0);
            check("rdata",        32'(e.port ? busa.rdata1 : busa.rdata0), 32'(e.data));
        end else begin
            check("rvalid0_idle", 32'(busa.rvalid0), 32'd0);
            check("rvalid1_idle", 32'(busa.rvalid1), 32'd0);
        end
        check("b_rvalid0", 32'(busb.rvalid0), 32'd0);
        check("b_rvalid1", 32'(busb.rvalid1), 32'd0);
    end

    initial begin
        cyc      = 0;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        for (int i = 0; i < 512; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        mem_a[9'h010] = 8'hA5;
        idle_all();

        // Reset holds grants low even with a request pending.
        repeat (2) step();
        busa.req0 = 1'b1; busa.addr0 = 9'h010;
        #2;
        check("rst_gnt0", 32'(busa.gnt0), 32'd0);
        check("rst_en",   32'(busa.sram_en), 32'd0);
        check("rst_rv0",  32'(busa.rvalid0), 32'd0);

        // Single read: grant at T, data at T+1, gone at T+2.
        step();
        reset = 1'b0;
        #2;
        check("t1_gnt0", 32'(busa.gnt0), 32'd1);
        check("t1_gnt1", 32'(busa.gnt1), 32'd0);
        check("t1_en",   32'(busa.sram_en), 32'd1);
        check("t1_we",   32'(busa.sram_we), 32'd0);
        check("t1_addr", 32'(busa.sram_addr), 32'h010);
        push_rd(1'b0, 8'hA5);
        step();
        busa.req0 = 1'b0;
        #2;
        check("t1_rv0",   32'(busa.rvalid0), 32'd1);
        check("t1_rd0",   32'(busa.rdata0), 32'hA5);
        check("t1_gnt0_off", 32'(busa.gnt0), 32'd0);
        step();
        #2;
        check("t1_rv0_gone", 32'(busa.rvalid0), 32'd0);
        step();

        // Fixed priority with starvation guard: port 1 wins on the 16th contended cycle.
        busa.req0 = 1'b1; busa.we0 = 1'b1; busa.addr0 = 9'h001; busa.wdata0 = 8'h11;
        busa.req1 = 1'b1; busa.we1 = 1'b1; busa.addr1 = 9'h002; busa.wdata1 = 8'h22;
        for (int i = 0; i < 20; i++) begin
            #2;
            check("t2_gnt0", 32'(busa.gnt0), 32'(i != 15));
            check("t2_gnt1", 32'(busa.gnt1), 32'(i == 15));
            check("t2_addr", 32'(busa.sram_addr), (i == 15) ? 32'h002 : 32'h001);
            step();
        end
        idle_all();
        step();

        // Round-robin: alternating grants starting at port 0.
        busb.req0 = 1'b1; busb.we0 = 1'b1; busb.addr0 = 9'h0AA; busb.wdata0 = 8'h01;
        busb.req1 = 1'b1; busb.we1 = 1'b1; busb.addr1 = 9'h155; busb.wdata1 = 8'h02;
        for (int i = 0; i < 8; i++) begin
            #2;
            check("t3_gnt0", 32'(busb.gnt0), 32'(i % 2 == 0));
            check("t3_gnt1", 32'(busb.gnt1), 32'(i % 2 == 1));
            check("t3_addr", 32'(busb.sram_addr), (i % 2 == 1) ? 32'h155 : 32'h0AA);
            step();
        end
        idle_all();
        step();

        // Write from port 1 then read-back from port 0 on the next cycle.
        busa.req1 = 1'b1; busa.we1 = 1'b1; busa.addr1 = 9'h1FF; busa.wdata1 = 8'h3C;
        #2;
        check("t4_gnt1",  32'(busa.gnt1), 32'd1);
        check("t4_we",    32'(busa.sram_we), 32'd1);
        check("t4_addr",  32'(busa.sram_addr), 32'h1FF);
        check("t4_wdata", 32'(busa.sram_wdata), 32'h3C);
        step();
        idle_all();
        busa.req0 = 1'b1; busa.we0 = 1'b0; busa.addr0 = 9'h1FF;
        #2;
        check("t4_gnt0", 32'(busa.gnt0), 32'd1);
        check("t4_rd_we", 32'(busa.sram_we), 32'd0);
        check("t4_rv1_t1", 32'(busa.rvalid1), 32'd0);
        push_rd(1'b0, 8'h3C);
        step();
        idle_all();
        #2;
        check("t4_rv0", 32'(busa.rvalid0), 32'd1);
        check("t4_rd0", 32'(busa.rdata0), 32'h3C);
        check("t4_rv1", 32'(busa.rvalid1), 32'd0);
        step();

        // Reset in flight: kills the pending read and clears wait count / last pointer.
        busa.req0 = 1'b1; busa.we0 = 1'b0; busa.addr0 = 9'h010;
        busa.req1 = 1'b1; busa.we1 = 1'b1; busa.addr1 = 9'h003; busa.wdata1 = 8'h33;
        for (int i = 0; i < 15; i++) begin
            if (i == 1) begin
                busb.req0 = 1'b1; busb.we0 = 1'b1; busb.addr0 = 9'h005; busb.wdata0 = 8'h55;
                busb.req1 = 1'b1; busb.we1 = 1'b1; busb.addr1 = 9'h006; busb.wdata1 = 8'h66;
            end
            #2;
            check("t5_a_gnt0", 32'(busa.gnt0), 32'd1);
            check("t5_a_gnt1", 32'(busa.gnt1), 32'd0);
            if (i >= 1) begin
                check("t5_b_gnt0", 32'(busb.gnt0), 32'(i % 2 == 1));
                check("t5_b_gnt1", 32'(busb.gnt1), 32'(i % 2 == 0));
            end
            if (i < 14) begin
                push_rd(1'b0, 8'hA5);
            end else begin
                reset = 1'b1;
                #1;
                check("t5_rst_gnt0", 32'(busa.gnt0), 32'd0);
                check("t5_rst_en",   32'(busa.sram_en), 32'd0);
                check("t5_rst_b_en", 32'(busb.sram_en), 32'd0);
            end
            step();
        end
        reset = 1'b0;
        #2;
        check("t5_killed_rv0", 32'(busa.rvalid0), 32'd0);
        check("t5_wait_clr",   32'(busa.gnt0), 32'd1);
        check("t5_last_rst",   32'(busb.gnt0), 32'd1);
        push_rd(1'b0, 8'hA5);
        step();
        idle_all();
        step();

        // Idle: nothing enabled, nothing granted.
        for (int i = 0; i < 10; i++) begin
            #2;
            check("t6_a_en",   32'(busa.sram_en), 32'd0);
            check("t6_a_we",   32'(busa.sram_we), 32'd0);
            check("t6_a_gnt",  32'({busa.gnt1, busa.gnt0}), 32'd0);
            check("t6_a_addr", 32'(busa.sram_addr), 32'd0);
            check("t6_b_en",   32'(busb.sram_en), 32'd0);
            check("t6_b_gnt",  32'({busb.gnt1, busb.gnt0}), 32'd0);
            step();
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
